issue_fifo_replay: RTL and testbench

- Parametrised successor to the controller's issue FIFO.
- Stores issued {command, addr, bank} words for the DRAM command scheduler.
- Adds a speculative read pointer with commit and rollback, so issued-but-unacknowledged commands can be replayed.
- Adds programmable full/virtual-full margins, exact occupancy outputs, sticky error flags and a synchronous flush.
- Sits between the command arbiter (writer) and the DRAM command issue FSM (reader/committer).

---
 rtl/issue_fifo_replay_pkg.sv | 32 +++
 rtl/issue_fifo_replay_ptr.sv | 39 +++
 rtl/issue_fifo_replay.sv | 131 +++++++++++++
 tb/tb_issue_fifo_replay.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/issue_fifo_replay_pkg.sv
// Shared constants for the replayable issue FIFO: entry layout and default sizing.
package issue_fifo_replay_pkg;

   localparam int unsigned ISU_FIFO_WIDTH = 21;
   localparam int unsigned ISU_FIFO_DEPTH = 32;

   // Entry layout: {command, addr, bank}
   localparam int unsigned CMD_MSB  = 20;
   localparam int unsigned CMD_LSB  = 17;
   localparam int unsigned ADDR_MSB = 16;
   localparam int unsigned ADDR_LSB = 3;
   localparam int unsigned BANK_MSB = 2;
   localparam int unsigned BANK_LSB = 0;

   localparam int unsigned ISU_FULL_MARGIN  = 4;
   localparam int unsigned ISU_VFULL_MARGIN = 8;

   // Assemble an entry from its fields.
   function automatic logic [ISU_FIFO_WIDTH-1:0] isu_pack(
      input logic [CMD_MSB-CMD_LSB:0]   cmd,
      input logic [ADDR_MSB-ADDR_LSB:0] addr,
      input logic [BANK_MSB-BANK_LSB:0] bank
   );
      logic [ISU_FIFO_WIDTH-1:0] w;
      w                    = '0;
      w[CMD_MSB:CMD_LSB]   = cmd;
      w[ADDR_MSB:ADDR_LSB] = addr;
      w[BANK_MSB:BANK_LSB] = bank;
      return w;
   endfunction

endpackage

// File: rtl/issue_fifo_replay_ptr.sv
// Wrapping FIFO pointer register with clear > load > increment priority.
module issue_fifo_ptr #(
   parameter int unsigned W = 6
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clear,
   input  logic         inc,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic [W-1:0] ptr
);

   logic [W-1:0] ptr_q, ptr_d;

   // Next pointer value.
   always_comb begin
      ptr_d = ptr_q;
      if (clear) begin
         ptr_d = '0;
      end else if (load) begin
         ptr_d = load_val;
      end else if (inc) begin
         ptr_d = ptr_q + W'(1);
      end
   end

   // Pointer register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= '0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

   assign ptr = ptr_q;

endmodule

// File: rtl/issue_fifo_replay.sv
// Issue FIFO with speculative read pointer: entries are issued via rd_ptr and only
// freed on commit (cm_ptr), so a rollback can re-present unretired commands in order.
module issue_fifo_replay
   import issue_fifo_replay_pkg::*;
#(
   parameter  int unsigned DATA_W       = ISU_FIFO_WIDTH,
   parameter  int unsigned DEPTH        = ISU_FIFO_DEPTH,
   parameter  int unsigned FULL_MARGIN  = ISU_FULL_MARGIN,
   parameter  int unsigned VFULL_MARGIN = ISU_VFULL_MARGIN,
   localparam int unsigned AW           = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              wen,
   input  logic [DATA_W-1:0] data_in,
   input  logic              ren,
   input  logic              commit,
   input  logic              rollback,
   output logic [DATA_W-1:0] data_out,
   output logic [DATA_W-1:0] data_out_pre,
   output logic              pre_valid,
   output logic              empty,
   output logic              full,
   output logic              virtual_full,
   output logic [AW:0]       used,
   output logic [AW:0]       pending,
   output logic              overflow,
   output logic              underflow
);

   localparam int unsigned PW = AW + 1;

   logic [PW-1:0]     wr_ptr, rd_ptr, cm_ptr;
   logic [PW-1:0]     free, rd_load_val;
   logic              at_cap, wr_ok, rd_inc, commit_ok;
   logic              overflow_q, overflow_d, underflow_q, underflow_d;
   logic [DATA_W-1:0] mem [DEPTH];

   // Occupancy and flags come from registered pointers only.
   always_comb begin
      used      = wr_ptr - cm_ptr;
      pending   = wr_ptr - rd_ptr;
      free      = PW'(DEPTH) - used;
      empty     = (pending == '0);
      pre_valid = (rd_ptr != cm_ptr);
      at_cap    = (used == PW'(DEPTH));
      full         = (free < PW'(FULL_MARGIN));
      virtual_full = (free < PW'(VFULL_MARGIN));
   end

   // Per-cycle pointer controls; rollback overrides issue and sees a same-cycle commit.
   always_comb begin
      wr_ok       = wen && !at_cap && !flush;
      commit_ok   = commit && pre_valid;
      rd_inc      = ren && !empty && !rollback;
      rd_load_val = cm_ptr + PW'(commit_ok);
   end

   issue_fifo_ptr #(.W(PW)) u_wr_ptr (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (flush),
      .inc      (wr_ok),
      .load     (1'b0),
      .load_val ('0),
      .ptr      (wr_ptr)
   );

   issue_fifo_ptr #(.W(PW)) u_rd_ptr (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (flush),
      .inc      (rd_inc),
      .load     (rollback),
      .load_val (rd_load_val),
      .ptr      (rd_ptr)
   );

   issue_fifo_ptr #(.W(PW)) u_cm_ptr (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (flush),
      .inc      (commit_ok),
      .load     (1'b0),
      .load_val ('0),
      .ptr      (cm_ptr)
   );

   // Sticky error flags; a rollback absorbs an ren so it is not an underflow.
   always_comb begin
      overflow_d  = overflow_q;
      underflow_d = underflow_q;
      if (flush) begin
         overflow_d  = 1'b0;
         underflow_d = 1'b0;
      end else begin
         if (wen && at_cap) begin
            overflow_d = 1'b1;
         end
         if ((ren && empty && !rollback) || (commit && !pre_valid)) begin
            underflow_d = 1'b1;
         end
      end
   end

   // Flag registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   assign overflow  = overflow_q;
   assign underflow = underflow_q;

   // Storage is not reset; occupancy is tracked by the pointers alone.
   always_ff @(posedge clk) begin
      if (wr_ok) begin
         mem[wr_ptr[AW-1:0]] <= data_in;
      end
   end

   assign data_out     = mem[rd_ptr[AW-1:0]];
   assign data_out_pre = mem[rd_ptr[AW-1:0] - AW'(1)];

endmodule

// File: tb/tb_issue_fifo_replay.sv
// Self-checking bench for issue_fifo_replay: fill/overflow sweep, vector table for
// issue/commit/rollback, scoreboarded wrap-around stream and async reset.
module tb_issue_fifo_replay;
   import issue_fifo_replay_pkg::*;

   localparam int unsigned DW = ISU_FIFO_WIDTH;
   localparam int unsigned AW = 5;

   logic          clk, rst_n, flush, wen, ren, commit, rollback;
   logic [DW-1:0] data_in, data_out, data_out_pre;
   logic          pre_valid, empty, full, virtual_full, overflow, underflow;
   logic [AW:0]   used, pending;

   int unsigned n_pass  = 0;
   int unsigned n_total = 0;

   issue_fifo_replay dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .flush        (flush),
      .wen          (wen),
      .data_in      (data_in),
      .ren          (ren),
      .commit       (commit),
      .rollback     (rollback),
      .data_out     (data_out),
      .data_out_pre (data_out_pre),
      .pre_valid    (pre_valid),
      .empty        (empty),
      .full         (full),
      .virtual_full (virtual_full),
      .used         (used),
      .pending      (pending),
      .overflow     (overflow),
      .underflow    (underflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic          fl, wen;
      logic [DW-1:0] din;
      logic          ren, cm, rb;
      logic [DW-1:0] dout;
      logic          cd;
      logic [DW-1:0] dpre;
      logic          cp;
      int unsigned   used, pend;
      logic          emp, pv, udf;
   } vec_t;

   vec_t          vecs[$];
   logic [DW-1:0] exp_q[$];

   function automatic vec_t mk(
      input logic fl, input logic wn, input logic [DW-1:0] din,
      input logic rn, input logic cm, input logic rb,
      input logic [DW-1:0] dout, input logic cd, input logic [DW-1:0] dpre, input logic cp,
      input int unsigned u, input int unsigned p, input logic emp, input logic pv,
      input logic udf
   );
      vec_t v;
      v.fl = fl; v.wen = wn; v.din = din; v.ren = rn; v.cm = cm; v.rb = rb;
      v.dout = dout; v.cd = cd; v.dpre = dpre; v.cp = cp;
      v.used = u; v.pend = p; v.emp = emp; v.pv = pv; v.udf = udf;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      flush = 0; wen = 0; ren = 0; commit = 0; rollback = 0; data_in = '0;
   endtask

   // Watchdog so the run always terminates.
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [DW-1:0] a, b, c, x, y, z, w, got;
      a = isu_pack(4'h1, 14'h0AAA, 3'd1);
      b = isu_pack(4'h2, 14'h0BBB, 3'd2);
      c = isu_pack(4'h3, 14'h0CCC, 3'd3);
      x = isu_pack(4'h9, 14'h1111, 3'd4);
      y = isu_pack(4'hA, 14'h2222, 3'd5);
      z = isu_pack(4'hB, 14'h3333, 3'd6);

      //          fl wen din ren cm rb  dout cd dpre cp used pend emp pv udf
      vecs.push_back(mk(0, 1, a, 0, 0, 0, a, 1, 0, 0, 1, 1, 0, 0, 0));
      vecs.push_back(mk(0, 1, b, 0, 0, 0, a, 1, 0, 0, 2, 2, 0, 0, 0));
      vecs.push_back(mk(0, 1, c, 0, 0, 0, a, 1, 0, 0, 3, 3, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 0, 0, b, 1, a, 1, 3, 2, 0, 1, 0));
      vecs.push_back(mk(0, 0, 0, 1, 0, 0, c, 1, b, 1, 3, 1, 0, 1, 0));
      vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, c, 1, 3, 0, 1, 1, 0));
      vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, c, 1, 2, 0, 1, 1, 0));
      vecs.push_back(mk(0, 0, 0, 0, 0, 1, b, 1, 0, 0, 2, 2, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 0, 0, c, 1, b, 1, 2, 1, 0, 1, 0));
      vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, c, 1, 2, 0, 1, 1, 0));
      vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, c, 1, 1, 0, 1, 1, 0));
      vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, a, 1, 0, 0, 0, 0, 1, 0, 0));
      vecs.push_back(mk(0, 1, x, 0, 0, 0, x, 1, 0, 0, 1, 1, 0, 0, 0));
      vecs.push_back(mk(0, 1, y, 0, 0, 0, x, 1, 0, 0, 2, 2, 0, 0, 0));
      vecs.push_back(mk(0, 1, z, 0, 0, 0, x, 1, 0, 0, 3, 3, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 0, 0, y, 1, x, 1, 3, 2, 0, 1, 0));
      vecs.push_back(mk(0, 0, 0, 1, 0, 0, z, 1, y, 1, 3, 1, 0, 1, 0));
      vecs.push_back(mk(0, 0, 0, 0, 1, 1, y, 1, 0, 0, 2, 2, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 0, 1, y, 1, 0, 0, 2, 2, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 1, 0, 0, z, 1, y, 1, 2, 1, 0, 1, 0));
      vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, z, 1, 2, 0, 1, 1, 0));
      vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, z, 1, 2, 0, 1, 1, 1));
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, x, 1, 0, 0, 0, 0, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 0, 1, 0, x, 1, 0, 0, 0, 0, 1, 0, 1));
      vecs.push_back(mk(1, 1, c, 0, 0, 0, x, 1, 0, 0, 0, 0, 1, 0, 0));

      // Reset state
      idle();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      check("rst empty", empty, 1);
      check("rst full", full, 0);
      check("rst vfull", virtual_full, 0);
      check("rst used", used, 0);
      check("rst pending", pending, 0);
      check("rst pre_valid", pre_valid, 0);
      check("rst overflow", overflow, 0);
      check("rst underflow", underflow, 0);

      // Fill to capacity, then one dropped write
      for (int k = 1; k <= 32; k++) begin
         wen = 1; data_in = DW'(k);
         tick();
         check($sformatf("fill%0d used", k), used, k);
         check($sformatf("fill%0d full", k), full, (k >= 29) ? 1 : 0);
         check($sformatf("fill%0d vfull", k), virtual_full, (k >= 25) ? 1 : 0);
         check($sformatf("fill%0d overflow", k), overflow, 0);
      end
      data_in = DW'(33);
      tick();
      idle();
      check("ovf flag", overflow, 1);
      check("ovf used", used, 32);
      check("ovf data_out", data_out, 1);
      flush = 1;
      tick();
      idle();
      check("flush overflow", overflow, 0);
      check("flush used", used, 0);
      check("flush empty", empty, 1);

      // Vector table
      foreach (vecs[i]) begin
         flush = vecs[i].fl; wen = vecs[i].wen; data_in = vecs[i].din;
         ren = vecs[i].ren; commit = vecs[i].cm; rollback = vecs[i].rb;
         tick();
         idle();
         if (vecs[i].cd) check($sformatf("v%0d data_out", i), data_out, vecs[i].dout);
         if (vecs[i].cp) check($sformatf("v%0d data_out_pre", i), data_out_pre, vecs[i].dpre);
         check($sformatf("v%0d used", i), used, vecs[i].used);
         check($sformatf("v%0d pending", i), pending, vecs[i].pend);
         check($sformatf("v%0d empty", i), empty, vecs[i].emp);
         check($sformatf("v%0d pre_valid", i), pre_valid, vecs[i].pv);
         check($sformatf("v%0d underflow", i), underflow, vecs[i].udf);
         check($sformatf("v%0d overflow", i), overflow, 0);
         check($sformatf("v%0d full", i), full, 0);
      end

      // Wrap-around stream: issue trails write by one cycle, commit by two
      flush = 1;
      tick();
      idle();
      for (int t = 0; t <= 101; t++) begin
         wen    = (t < 100);
         ren    = (t >= 1 && t <= 100);
         commit = (t >= 2);
         if (wen) begin
            w = DW'($urandom);
            data_in = w;
            exp_q.push_back(w);
         end
         if (ren) begin
            if (exp_q.size() == 0) begin
               check($sformatf("stream t%0d queue nonempty", t), 0, 1);
            end else begin
               got = exp_q.pop_front();
               check($sformatf("stream t%0d data_out", t), data_out, got);
            end
         end
         tick();
         check($sformatf("stream t%0d used<=2", t), (used <= 2) ? 1 : 0, 1);
      end
      idle();
      check("stream end used", used, 0);
      check("stream end empty", empty, 1);
      check("stream end pre_valid", pre_valid, 0);
      check("stream end overflow", overflow, 0);
      check("stream end underflow", underflow, 0);
      check("stream end queue", exp_q.size(), 0);

      // Asynchronous reset mid-stream, between clock edges
      commit = 1;
      tick();
      idle();
      check("pre-rst underflow", underflow, 1);
      for (int k = 0; k < 3; k++) begin
         wen = 1; data_in = DW'(k + 7);
         tick();
      end
      idle();
      ren = 1;
      tick();
      idle();
      check("pre-rst used", used, 3);
      check("pre-rst pre_valid", pre_valid, 1);
      #2 rst_n = 1'b0;
      #1;
      check("async rst used", used, 0);
      check("async rst pending", pending, 0);
      check("async rst empty", empty, 1);
      check("async rst pre_valid", pre_valid, 0);
      check("async rst underflow", underflow, 0);
      check("async rst full", full, 0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      tick();
      check("post-rst empty", empty, 1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
